// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S playback engine.
package aud_pkg;

   localparam int DATA_W      = 16;
   localparam int ADDR_W      = 20;
   localparam int BIT_CNT_MAX = 16;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      PLAY,
      PAUSE
   } state_t;

endpackage

// File: rtl/aud_i2s_serializer.sv
// MSB-first serializer: one bit per clock after a load, zeros once the counter saturates.
module aud_i2s_serializer #(
   parameter int DATA_W = aud_pkg::DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] word,
   output logic              last,
   output logic              dacdat
);
   import aud_pkg::*;

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_PRE0 = CNT_W'(DATA_W - 2);

   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              dacdat_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst || clear) begin
         shift_q  <= '0;
         cnt_q    <= CNT_MAX;
         dacdat_q <= 1'b0;
      end else if (load) begin
         shift_q  <= {word[DATA_W-2:0], 1'b0};
         cnt_q    <= '0;
         dacdat_q <= word[DATA_W-1];
      end else if (cnt_q != CNT_MAX) begin
         // The shifter is empty by the time bit 0 has gone out, so the saturated bit reads 0.
         shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
         cnt_q    <= cnt_q + CNT_W'(1);
         dacdat_q <= shift_q[DATA_W-1];
      end
   end

   assign last   = (cnt_q == CNT_PRE0);
   assign dacdat = dacdat_q;

endmodule

// File: rtl/aud_player.sv
// I2S playback engine: reads mono samples from SRAM and plays each on both DAC channels.
module aud_player #(
   parameter int DATA_W = aud_pkg::DATA_W,
   parameter int ADDR_W = aud_pkg::ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_lrc,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_dacdat,
   output logic              o_playing,
   output logic              o_done
);
   import aud_pkg::*;

   state_t            state_q;
   logic              lrc_q;
   logic              pause_q;
   logic              end_q;
   logic              done_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sample_q;

   logic              l_edge;
   logic              r_edge;
   logic              pause_enter;
   logic              ser_load;
   logic              ser_clear;
   logic              ser_last;
   logic              finish;
   logic [DATA_W-1:0] ser_word;

   assign l_edge      = lrc_q & ~i_lrc;
   assign r_edge      = ~lrc_q & i_lrc;
   assign pause_enter = (state_q == PLAY) && l_edge && pause_q;
   assign ser_load    = ((state_q == SYNC) && l_edge) ||
                        ((state_q == PLAY) && (r_edge || (l_edge && !pause_q)));
   assign ser_clear   = i_stop || pause_enter;
   // Left channel takes fresh SRAM data; right channel replays the latched copy.
   assign ser_word    = l_edge ? i_sram_data : sample_q;
   assign finish      = (state_q == PLAY) && end_q && ser_last && !ser_load;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         lrc_q    <= 1'b0;
         pause_q  <= 1'b0;
         end_q    <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         sample_q <= '0;
      end else begin
         lrc_q  <= i_lrc;
         done_q <= 1'b0;
         if (ser_load && l_edge)
            sample_q <= i_sram_data;
         if (i_stop) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pause_q <= 1'b0;
            end_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (i_start) state_q <= SYNC;
               SYNC: begin
                  if (i_pause) pause_q <= 1'b1;
                  if (l_edge)  state_q <= PLAY;
               end
               PLAY: begin
                  if (i_pause) pause_q <= 1'b1;
                  if (pause_enter) begin
                     state_q <= PAUSE;
                     pause_q <= 1'b0;
                  end else if (finish) begin
                     state_q <= IDLE;
                     addr_q  <= '0;
                     end_q   <= 1'b0;
                     pause_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (r_edge) begin
                     // The last word's address is held so the right channel still finishes.
                     if (addr_q == i_end_addr) end_q  <= 1'b1;
                     else                      addr_q <= addr_q + ADDR_W'(1);
                  end
               end
               PAUSE: if (i_start) state_q <= SYNC;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   aud_i2s_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .clear  (ser_clear),
      .load   (ser_load),
      .word   (ser_word),
      .last   (ser_last),
      .dacdat (o_dacdat)
   );

   assign o_address = addr_q;
   assign o_playing = (state_q == SYNC) || (state_q == PLAY);
   assign o_done    = done_q;

endmodule

// File: tb/tb_aud_player.sv
// Directed bench for aud_player: play, sync, pause/resume, stop, reset and short-LRC cases.
module tb_aud_player;

   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          lrc;
   logic          start;
   logic          pause;
   logic          stop;
   logic [AW-1:0] end_addr;
   logic [15:0]   sram_data;
   logic [AW-1:0] address;
   logic          dacdat;
   logic          playing;
   logic          done;

   logic [15:0] mem [16];
   int ph;
   int half;
   int n_pass   = 0;
   int n_chk    = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   assign sram_data = mem[address[3:0]];

   always @(posedge clk) if (done === 1'b1) done_cnt++;

   aud_player dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_lrc       (lrc),
      .i_start     (start),
      .i_pause     (pause),
      .i_stop      (stop),
      .i_end_addr  (end_addr),
      .i_sram_data (sram_data),
      .o_address   (address),
      .o_dacdat    (dacdat),
      .o_playing   (playing),
      .o_done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample point is 1 ns after the rising edge; command pulses last one cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
      start = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
      ph++;
      if (ph >= half) begin
         ph  = 0;
         lrc = ~lrc;
      end
   endtask

   task automatic run_to_edge(input logic lvl);
      int n = 0;
      while (!(lrc == lvl && ph == 0) && n < 400) begin
         cyc();
         n++;
      end
      if (n >= 400) check("edge_timeout", n, 0);
   endtask

   task automatic grab(input int nbits, output logic [15:0] w, output int done_at,
                       output logic [AW-1:0] a0);
      w       = '0;
      done_at = -1;
      a0      = '0;
      for (int i = 0; i < nbits; i++) begin
         cyc();
         w = {w[14:0], dacdat};
         if (done === 1'b1) done_at = i;
         if (i == 0) a0 = address;
      end
   endtask

   task automatic quiet(input int n, input logic [AW-1:0] exp_addr, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         cyc();
         if (dacdat !== 1'b0 || address !== exp_addr) bad++;
      end
   endtask

   task automatic start_cmd();
      run_to_edge(1'b1);
      repeat (4) cyc();
      start = 1'b1;
      cyc();
   endtask

   initial begin
      logic [15:0]   w;
      int            da;
      int            bad;
      int            n;
      int            d0;
      logic [AW-1:0] a0;

      rst = 1'b1; lrc = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
      end_addr = 1; half = 32; ph = 1;
      for (int i = 0; i < 16; i++) mem[i] = 16'(i) * 16'h1111;
      mem[0] = 16'hA5C3;
      mem[1] = 16'h0F0F;
      mem[3] = 16'hBEEF;
      mem[4] = 16'hC0DE;

      repeat (3) cyc();
      check("rst_address", address, 0);
      check("rst_dacdat", dacdat, 0);
      check("rst_playing", playing, 0);
      check("rst_done", done, 0);
      rst = 1'b0;

      // Normal play, started mid right channel so the sync wait is exercised.
      start_cmd();
      check("sync_playing", playing, 1);
      bad = 0;
      n   = 0;
      while (!(lrc == 1'b0 && ph == 0) && n < 400) begin
         cyc();
         n++;
         if (dacdat !== 1'b0 || address !== '0) bad = 1;
      end
      check("sync_quiet", bad, 0);
      grab(16, w, da, a0);
      check("w0_left", w, 16'hA5C3);
      check("w0_left_addr", a0, 0);
      run_to_edge(1'b1);
      grab(16, w, da, a0);
      check("w0_right", w, 16'hA5C3);
      check("w0_right_addr", a0, 1);
      run_to_edge(1'b0);
      grab(16, w, da, a0);
      check("w1_left", w, 16'h0F0F);
      check("w1_left_done", da, 32'hFFFF_FFFF);
      run_to_edge(1'b1);
      grab(16, w, da, a0);
      check("w1_right", w, 16'h0F0F);
      check("w1_right_addr", a0, 1);
      check("done_at_bit0", da, 15);
      cyc();
      check("end_playing", playing, 0);
      check("end_address", address, 0);
      check("end_dacdat", dacdat, 0);
      check("end_done_count", done_cnt, 1);

      // Pause requested mid left channel of word 3, then resume.
      end_addr = 7;
      start_cmd();
      run_to_edge(1'b0);
      repeat (3) begin
         run_to_edge(1'b1);
         run_to_edge(1'b0);
      end
      grab(16, w, da, a0);
      check("w3_left", w, 16'hBEEF);
      check("w3_left_addr", a0, 3);
      pause = 1'b1;
      cyc();
      run_to_edge(1'b1);
      grab(16, w, da, a0);
      check("w3_right", w, 16'hBEEF);
      check("w3_right_addr", a0, 4);
      run_to_edge(1'b0);
      cyc();
      check("pause_playing", playing, 0);
      check("pause_address", address, 4);
      check("pause_dacdat", dacdat, 0);
      quiet(40, 4, bad);
      check("pause_quiet", bad, 0);
      start_cmd();
      run_to_edge(1'b0);
      grab(8, w, da, a0);
      check("resume_w4_msbyte", w[7:0], 8'hC0);
      check("resume_addr", a0, 4);

      // Stop and start together mid-word: stop wins.
      d0    = done_cnt;
      stop  = 1'b1;
      start = 1'b1;
      cyc();
      check("stop_playing", playing, 0);
      check("stop_address", address, 0);
      check("stop_dacdat", dacdat, 0);
      quiet(40, 0, bad);
      check("stop_quiet", bad, 0);
      check("stop_no_done", done_cnt, d0);

      // Reset at bit 7 of a right channel.
      start_cmd();
      run_to_edge(1'b0);
      run_to_edge(1'b1);
      repeat (9) cyc();
      check("pre_rst_bit7", dacdat, 1);
      check("pre_rst_addr", address, 1);
      rst = 1'b1;
      cyc();
      check("mid_rst_address", address, 0);
      check("mid_rst_dacdat", dacdat, 0);
      check("mid_rst_playing", playing, 0);
      check("mid_rst_done", done, 0);
      rst = 1'b0;
      quiet(80, 0, bad);
      check("post_rst_quiet", bad, 0);
      check("post_rst_playing", playing, 0);

      // Short LRC: half-period of 10 truncates each word to bits 15..6.
      half = 10;
      start_cmd();
      run_to_edge(1'b0);
      grab(10, w, da, a0);
      check("short_w0_left", w[9:0], 10'h297);
      check("short_w0_left_addr", a0, 0);
      run_to_edge(1'b1);
      grab(10, w, da, a0);
      check("short_w0_right", w[9:0], 10'h297);
      check("short_w0_right_addr", a0, 1);
      run_to_edge(1'b0);
      grab(10, w, da, a0);
      check("short_w1_left", w[9:0], 10'h03C);
      run_to_edge(1'b1);
      grab(10, w, da, a0);
      check("short_w1_right", w[9:0], 10'h03C);
      check("short_w1_right_addr", a0, 2);
      stop = 1'b1;
      cyc();
      check("short_stop_playing", playing, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
